// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TileLink-UL opcodes, slave FSM states and width defaults
package tlul_pkg;

  localparam int TL_ADDR_W   = 32;
  localparam int TL_DATA_W   = 32;
  localparam int TL_SIZE_W   = 3;
  localparam int TL_OPCODE_W = 3;

  localparam logic [2:0] TL_GET         = 3'h0;
  localparam logic [2:0] TL_PUT_FULL    = 3'h1;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'h2;
  localparam logic [2:0] TL_ACK         = 3'h3;
  localparam logic [2:0] TL_ACK_DATA    = 3'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } tl_state_e;

endpackage

// File: rtl/tlul_mem_array.sv
// rtl/tlul_mem_array.sv - DEPTH x DATA_WIDTH byte-enabled RAM, one write and one registered read port
module tlul_mem_array #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_24,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [MASK_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  // Read data only moves on a read strobe, so it stays put for the whole response
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Byte-lane writes and read-data register; contents are deliberately not reset
  always_ff @(posedge clk_24) begin
    if (we) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (wmask[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tlul_mem_slave.sv
// rtl/tlul_mem_slave.sv - TL-UL memory slave; TLUL_MEM_SLAVE_PARTIAL_EN enables PutPartialData
module tlul_mem_slave
  import tlul_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = TL_ADDR_W,
  parameter int                    DATA_WIDTH   = TL_DATA_W,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = TL_SIZE_W,
  parameter int                    OPCODE_WIDTH = TL_OPCODE_W,
  parameter int                    DEPTH        = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    LATENCY      = 1
) (
  input  logic                    clk_24,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int                    OFF_W    = $clog2(MASK_WIDTH);
  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(DEPTH * MASK_WIDTH);
  localparam logic [3:0]            CNT_INIT = 4'(LATENCY - 1);

  tl_state_e                 state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      a_ready_q, a_ready_d;
  logic [OPCODE_WIDTH-1:0]   d_opcode_q, d_opcode_d;
  logic                      d_error_q, d_error_d;
  logic                      rdata_sel_q, rdata_sel_d;

  logic [ADDR_WIDTH-1:0]     a_off;
  logic                      is_get, is_put_full, is_put_partial;
  logic                      op_ok, range_ok, size_ok, req_err, accept;
  logic                      wr_en, rd_en;
  logic [MASK_WIDTH-1:0]     wr_mask;
  logic [DATA_WIDTH-1:0]     rd_data;

  // Decode and vet the request presented on channel A
  always_comb begin
    a_off          = a_address - BASE_ADDR;
    is_get         = (a_opcode == OPCODE_WIDTH'(TL_GET));
    is_put_full    = (a_opcode == OPCODE_WIDTH'(TL_PUT_FULL));
    is_put_partial = (a_opcode == OPCODE_WIDTH'(TL_PUT_PARTIAL));
`ifdef TLUL_MEM_SLAVE_PARTIAL_EN
    op_ok          = is_get || is_put_full || is_put_partial;
`else
    op_ok          = is_get || is_put_full;
`endif
    // Addresses below the base wrap to a huge offset and fail this compare too
    range_ok       = (a_off < SPAN);
    size_ok        = (a_size <= SIZE_WIDTH'(OFF_W));
    req_err        = !(op_ok && range_ok && size_ok);
    accept         = a_valid && a_ready_q;
    wr_en          = accept && !req_err && (is_put_full || is_put_partial);
    rd_en          = accept && !req_err && is_get;
    wr_mask        = is_put_full ? '1 : a_mask;
  end

  tlul_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MASK_WIDTH (MASK_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk_24 (clk_24),
    .we     (wr_en),
    .waddr  (a_off[OFF_W +: IDX_W]),
    .wmask  (wr_mask),
    .wdata  (a_data),
    .re     (rd_en),
    .raddr  (a_off[OFF_W +: IDX_W]),
    .rdata  (rd_data)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, hold response in RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_opcode_d  = d_opcode_q;
    d_error_d   = d_error_q;
    rdata_sel_d = rdata_sel_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          d_opcode_d  = is_get ? OPCODE_WIDTH'(TL_ACK_DATA) : OPCODE_WIDTH'(TL_ACK);
          d_error_d   = req_err;
          rdata_sel_d = is_get && !req_err;
          cnt_d       = CNT_INIT;
          state_d     = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a_ready is registered so it only rises the cycle after the D handshake
    a_ready_d = (state_d == IDLE);
  end

  // State and response registers with synchronous active-low reset
  always_ff @(posedge clk_24) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      a_ready_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_error_q   <= 1'b0;
      rdata_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_ready_q   <= a_ready_d;
      d_opcode_q  <= d_opcode_d;
      d_error_q   <= d_error_d;
      rdata_sel_q <= rdata_sel_d;
    end
  end

  assign a_ready  = a_ready_q;
  assign d_valid  = (state_q == RESP);
  assign d_opcode = d_opcode_q;
  assign d_error  = d_error_q;
  assign d_data   = rdata_sel_q ? rd_data : '0;

endmodule

// File: tb/tb_tlul_mem_slave.sv
// tb/tb_tlul_mem_slave.sv - randomized self-checking bench, LATENCY=1 and LATENCY=5 instances
module tb_tlul_mem_slave;

  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk_24 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        a_valid   [2];
  logic        a_ready   [2];
  logic [2:0]  a_opcode  [2];
  logic [2:0]  a_size    [2];
  logic [31:0] a_address [2];
  logic [3:0]  a_mask    [2];
  logic [31:0] a_data    [2];
  logic        d_valid   [2];
  logic        d_ready   [2];
  logic [2:0]  d_opcode  [2];
  logic [31:0] d_data    [2];
  logic        d_error   [2];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [2][16];
  logic [31:0] base_of [2];
  int          lat_of  [2];

  always #5 clk_24 = ~clk_24;

  tlul_mem_slave #(.LATENCY(1)) u_dut0 (
    .clk_24(clk_24), .rst_n(rst_n),
    .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_opcode(a_opcode[0]), .a_size(a_size[0]),
    .a_address(a_address[0]), .a_mask(a_mask[0]), .a_data(a_data[0]),
    .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_opcode(d_opcode[0]), .d_data(d_data[0]),
    .d_error(d_error[0])
  );

  tlul_mem_slave #(.LATENCY(5), .BASE_ADDR(BASE1)) u_dut1 (
    .clk_24(clk_24), .rst_n(rst_n),
    .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_opcode(a_opcode[1]), .a_size(a_size[1]),
    .a_address(a_address[1]), .a_mask(a_mask[1]), .a_data(a_data[1]),
    .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_opcode(d_opcode[1]), .d_data(d_data[1]),
    .d_error(d_error[1])
  );

  // Behavioural reference: decide the response from the protocol rules and update the model
  task automatic model_txn(input int s, input logic [2:0] op, input logic [31:0] addr,
                           input logic [2:0] sz, input logic [3:0] mk, input logic [31:0] dt,
                           output logic [2:0] e_op, output logic [31:0] e_data, output logic e_err);
    bit partial_en;
    bit bad;
    int idx;
`ifdef TLUL_MEM_SLAVE_PARTIAL_EN
    partial_en = 1;
`else
    partial_en = 0;
`endif
    bad = (addr < base_of[s]) || (addr >= base_of[s] + 64) || (sz > 2) ||
          !(op == 0 || op == 1 || (op == 2 && partial_en));
    idx = bad ? 0 : int'((addr - base_of[s]) / 4);
    e_op   = (op == 0) ? 3'h4 : 3'h3;
    e_err  = bad;
    e_data = (op == 0 && !bad) ? model[s][idx] : 32'h0;
    if (!bad && op == 1) model[s][idx] = dt;
    if (!bad && op == 2) begin
      for (int b = 0; b < 4; b++)
        if (mk[b]) model[s][idx][b*8 +: 8] = dt[b*8 +: 8];
    end
  endtask

  // Drive one A request, wait for D, optionally stall d_ready, then complete; flags protocol breaks
  task automatic txn(input int s, input logic [2:0] op, input logic [31:0] addr,
                     input logic [2:0] sz, input logic [3:0] mk, input logic [31:0] dt,
                     input int hold, output logic [2:0] r_op, output logic [31:0] r_data,
                     output logic r_err, output int lat);
    int n;
    n = 0; lat = 0; r_op = 'x; r_data = 'x; r_err = 1'bx;
    @(negedge clk_24);
    while (a_ready[s] !== 1'b1 && n < 20) begin @(negedge clk_24); n++; end
    checks++;
    if (a_ready[s] !== 1'b1) begin
      errors++; $display("FAIL a_ready_timeout dut%0d a_ready=%b required 1", s, a_ready[s]);
      return;
    end
    a_valid[s] = 1'b1; a_opcode[s] = op; a_address[s] = addr;
    a_size[s] = sz; a_mask[s] = mk; a_data[s] = dt;
    @(posedge clk_24); #1;
    a_valid[s] = 1'b0; a_data[s] = $urandom; a_mask[s] = 4'($urandom);
    do begin
      @(negedge clk_24); lat++;
      if (d_valid[s] !== 1'b1) begin
        checks++;
        if (a_ready[s] !== 1'b0) begin
          errors++; $display("FAIL a_ready_in_wait dut%0d a_ready=%b required 0", s, a_ready[s]);
        end
      end
    end while (d_valid[s] !== 1'b1 && lat < 40);
    checks++;
    if (d_valid[s] !== 1'b1) begin
      errors++; $display("FAIL d_valid_timeout dut%0d d_valid=%b required 1", s, d_valid[s]);
      return;
    end
    r_op = d_opcode[s]; r_data = d_data[s]; r_err = d_error[s];
    repeat (hold) begin
      @(negedge clk_24);
      checks++;
      if (d_valid[s] !== 1'b1 || a_ready[s] !== 1'b0 || d_opcode[s] !== r_op ||
          d_data[s] !== r_data || d_error[s] !== r_err) begin
        errors++;
        $display("FAIL hold_stable dut%0d v=%b rdy=%b op=%h data=%h err=%b required v=1 rdy=0 op=%h data=%h err=%b",
                 s, d_valid[s], a_ready[s], d_opcode[s], d_data[s], d_error[s], r_op, r_data, r_err);
      end
    end
    d_ready[s] = 1'b1;
    @(posedge clk_24); #1;
    d_ready[s] = 1'b0;
    @(negedge clk_24);
    checks++;
    if (d_valid[s] !== 1'b0 || a_ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL after_d_handshake dut%0d d_valid=%b a_ready=%b required d_valid=0 a_ready=1",
               s, d_valid[s], a_ready[s]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_24);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (a_ready[s] !== 1'b0 || d_valid[s] !== 1'b0 || d_opcode[s] !== 3'h0 ||
          d_data[s] !== 32'h0 || d_error[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values dut%0d a_ready=%b d_valid=%b d_opcode=%h d_data=%h d_error=%b required all 0",
                 s, a_ready[s], d_valid[s], d_opcode[s], d_data[s], d_error[s]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [2:0] e_op, r_op; logic [31:0] e_d, r_d, v; logic e_e, r_e; int lat;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) begin
        v = $urandom;
        model_txn(s, 3'h1, base_of[s] + 32'(w * 4), 3'd2, 4'hf, v, e_op, e_d, e_e);
        txn(s, 3'h1, base_of[s] + 32'(w * 4), 3'd2, 4'hf, v, 0, r_op, r_d, r_e, lat);
        checks++;
        if (r_op !== e_op || r_d !== e_d || r_e !== e_e) begin
          errors++; $display("FAIL fill dut%0d w%0d op=%h data=%h err=%b required op=%h data=%h err=%b",
                             s, w, r_op, r_d, r_e, e_op, e_d, e_e);
        end
      end
    end
  endtask

  task automatic test_put_get();
    logic [2:0] r_op; logic [31:0] r_d; logic r_e; int lat;
    model[0][0] = 32'hA5A5_1234;
    txn(0, 3'h1, 32'h0, 3'd2, 4'hf, 32'hA5A5_1234, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h3 || r_e !== 1'b0 || r_d !== 32'h0 || lat != 1) begin
      errors++; $display("FAIL put_full op=%h err=%b data=%h lat=%0d required op=3 err=0 data=0 lat=1",
                         r_op, r_e, r_d, lat);
    end
    txn(0, 3'h0, 32'h0, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h4 || r_e !== 1'b0 || r_d !== 32'hA5A5_1234 || lat != 1) begin
      errors++; $display("FAIL get_back op=%h err=%b data=%h lat=%0d required op=4 err=0 data=a5a51234 lat=1",
                         r_op, r_e, r_d, lat);
    end
  endtask

  task automatic test_latency();
    logic [2:0] r_op; logic [31:0] r_d; logic r_e; int lat;
    txn(1, 3'h0, BASE1 + 32'h4, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (lat != 5 || r_op !== 3'h4 || r_e !== 1'b0 || r_d !== model[1][1]) begin
      errors++; $display("FAIL latency5 lat=%0d op=%h err=%b data=%h required lat=5 op=4 err=0 data=%h",
                         lat, r_op, r_e, r_d, model[1][1]);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] r_op; logic [31:0] r_d; logic r_e; int lat;
    for (int s = 0; s < 2; s++) begin
      txn(s, 3'h0, base_of[s] + 32'h24, 3'd2, 4'hf, 32'h0, 7, r_op, r_d, r_e, lat);
      checks++;
      if (r_op !== 3'h4 || r_e !== 1'b0 || r_d !== model[s][9]) begin
        errors++; $display("FAIL backpressure dut%0d op=%h err=%b data=%h required op=4 err=0 data=%h",
                           s, r_op, r_e, r_d, model[s][9]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0] r_op; logic [31:0] r_d; logic r_e; int lat;
    txn(0, 3'h0, 32'h40, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h4 || r_e !== 1'b1 || r_d !== 32'h0) begin
      errors++; $display("FAIL get_out_of_range op=%h err=%b data=%h required op=4 err=1 data=0", r_op, r_e, r_d);
    end
    txn(0, 3'h1, 32'h10, 3'd3, 4'hf, 32'h5555_AAAA, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h3 || r_e !== 1'b1 || r_d !== 32'h0) begin
      errors++; $display("FAIL put_size3 op=%h err=%b data=%h required op=3 err=1 data=0", r_op, r_e, r_d);
    end
    txn(0, 3'h0, 32'h10, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_d !== model[0][4] || r_e !== 1'b0) begin
      errors++; $display("FAIL size3_unchanged data=%h err=%b required data=%h err=0", r_d, r_e, model[0][4]);
    end
    txn(1, 3'h0, BASE1 - 32'h4, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h4 || r_e !== 1'b1 || r_d !== 32'h0) begin
      errors++; $display("FAIL get_below_base op=%h err=%b data=%h required op=4 err=1 data=0", r_op, r_e, r_d);
    end
    txn(0, 3'h6, 32'h8, 3'd2, 4'hf, 32'h1234_5678, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h3 || r_e !== 1'b1 || r_d !== 32'h0) begin
      errors++; $display("FAIL bad_opcode op=%h err=%b data=%h required op=3 err=1 data=0", r_op, r_e, r_d);
    end
  endtask

  task automatic test_partial();
    logic [2:0] r_op; logic [31:0] r_d; logic r_e; int lat;
    logic [31:0] exp_rb; logic exp_err;
`ifdef TLUL_MEM_SLAVE_PARTIAL_EN
    exp_rb = 32'hFF22_FF44; exp_err = 1'b0;
`else
    exp_rb = 32'hFFFF_FFFF; exp_err = 1'b1;
`endif
    model[0][2] = exp_rb;
    txn(0, 3'h1, 32'h8, 3'd2, 4'hf, 32'hFFFF_FFFF, 0, r_op, r_d, r_e, lat);
    txn(0, 3'h2, 32'h8, 3'd2, 4'b0101, 32'h1122_3344, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_op !== 3'h3 || r_e !== exp_err || r_d !== 32'h0) begin
      errors++; $display("FAIL put_partial op=%h err=%b data=%h required op=3 err=%b data=0", r_op, r_e, r_d, exp_err);
    end
    txn(0, 3'h0, 32'h8, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_d !== exp_rb) begin
      errors++; $display("FAIL partial_readback data=%h required %h", r_d, exp_rb);
    end
  endtask

  task automatic test_random();
    logic [2:0] op, sz, e_op, r_op; logic [31:0] addr, dt, e_d, r_d; logic [3:0] mk;
    logic e_e, r_e; int lat, r;
    for (int i = 0; i < 120; i++) begin
      int s;
      s = i % 2;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 3'h0 : (r < 7) ? 3'h1 : (r < 9) ? 3'h2 : 3'($urandom_range(3, 7));
      addr = base_of[s] - 32'h8 + 32'($urandom_range(0, 16'h57));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      mk = 4'($urandom); dt = $urandom;
      model_txn(s, op, addr, sz, mk, dt, e_op, e_d, e_e);
      txn(s, op, addr, sz, mk, dt, $urandom_range(0, 2), r_op, r_d, r_e, lat);
      checks++;
      if (r_op !== e_op || r_d !== e_d || r_e !== e_e || lat != lat_of[s]) begin
        errors++;
        $display("FAIL random%0d dut%0d op%h@%h sz%0d got op=%h data=%h err=%b lat=%0d required op=%h data=%h err=%b lat=%0d",
                 i, s, op, addr, sz, r_op, r_d, r_e, lat, e_op, e_d, e_e, lat_of[s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] r_op; logic [31:0] r_d; logic r_e; int lat, n;
    n = 0;
    @(negedge clk_24);
    while (a_ready[1] !== 1'b1 && n < 20) begin @(negedge clk_24); n++; end
    a_valid[1] = 1'b1; a_opcode[1] = 3'h1; a_address[1] = BASE1 + 32'hC;
    a_size[1] = 3'd2; a_mask[1] = 4'hf; a_data[1] = 32'hDEAD_BEEF;
    @(posedge clk_24); #1;
    a_valid[1] = 1'b0;
    model[1][3] = 32'hDEAD_BEEF;
    @(negedge clk_24);
    checks++;
    if (a_ready[1] !== 1'b0 || d_valid[1] !== 1'b0) begin
      errors++; $display("FAIL mid_wait a_ready=%b d_valid=%b required 0 0", a_ready[1], d_valid[1]);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk_24);
    checks++;
    if (d_valid[1] !== 1'b0 || a_ready[1] !== 1'b0 || d_opcode[1] !== 3'h0) begin
      errors++; $display("FAIL mid_reset d_valid=%b a_ready=%b d_opcode=%h required 0 0 0",
                         d_valid[1], a_ready[1], d_opcode[1]);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk_24);
    checks++;
    if (d_valid[1] !== 1'b0) begin
      errors++; $display("FAIL dropped_resp d_valid=%b required 0", d_valid[1]);
    end
    txn(1, 3'h0, BASE1 + 32'hC, 3'd2, 4'hf, 32'h0, 0, r_op, r_d, r_e, lat);
    checks++;
    if (r_d !== 32'hDEAD_BEEF || r_e !== 1'b0) begin
      errors++; $display("FAIL reset_readback data=%h err=%b required deadbeef 0", r_d, r_e);
    end
  endtask

  initial begin
    base_of[0] = 32'h0; base_of[1] = BASE1;
    lat_of[0] = 1; lat_of[1] = 5;
    for (int s = 0; s < 2; s++) begin
      a_valid[s] = 1'b0; a_opcode[s] = '0; a_size[s] = '0; a_address[s] = '0;
      a_mask[s] = '0; a_data[s] = '0; d_ready[s] = 1'b0;
    end
    test_reset();
    test_fill();
    test_put_get();
    test_latency();
    test_backpressure();
    test_errors();
    test_partial();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tlul_mem_slave.md
Name: tlul_mem_slave

Overview:
- Parametrised TileLink-UL slave: word-addressed memory of DEPTH entries behind channels A and D.
- Successor to the fixed 4-entry slave model; adds byte masks, configurable response latency, held D-channel backpressure and error responses.
- Sits opposite tlul_master on the clk_24 domain as a synthesizable on-chip scratch memory and bench target.
- Single outstanding transaction.

Parameters:
- ADDR_WIDTH, 32, channel A address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- MASK_WIDTH, DATA_WIDTH/8, byte-lane mask width.
- SIZE_WIDTH, 3, a_size width.
- OPCODE_WIDTH, 3, opcode width.
- DEPTH, 16, number of memory words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*MASK_WIDTH.
- LATENCY, 1, cycles from A acceptance to D assertion; 1..15.

Ports:
- clk_24  in  1  clock
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  request valid
- a_ready  out  1  slave can accept request
- a_opcode  in  OPCODE_WIDTH  3'h0 Get, 3'h1 PutFullData, 3'h2 PutPartialData
- a_size  in  SIZE_WIDTH  log2 bytes
- a_address  in  ADDR_WIDTH  byte address
- a_mask  in  MASK_WIDTH  byte enables
- a_data  in  DATA_WIDTH  write data
- d_valid  out  1  response valid
- d_ready  in  1  master accepts response
- d_opcode  out  OPCODE_WIDTH  3'h3 AccessAck, 3'h4 AccessAckData
- d_data  out  DATA_WIDTH  read data; 0 for writes and errors
- d_error  out  1  request was denied

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk_24.
  - Reset values: a_ready=0, d_valid=0, d_opcode=0, d_data=0, d_error=0, FSM=IDLE, latency counter=0. Memory contents are not reset.
  - Reset mid-transaction drops it; no write is committed unless the A handshake already completed.
- FSM IDLE: a_ready=1.
  - On a_valid&&a_ready: capture the request, do the memory access in the same edge, load counter=LATENCY-1, go to WAIT.
  - If LATENCY==1, go directly to RESP; d_valid is asserted on the next cycle.
- FSM WAIT: a_ready=0. Decrement the counter each cycle; at 0 go to RESP.
- FSM RESP: a_ready=0, d_valid=1. d_opcode, d_data and d_error stay stable until d_ready.
  - On d_valid&&d_ready: d_valid=0 and return to IDLE; a_ready=1 the following cycle.
  - There is no same-cycle D-complete/A-accept overlap.
- Word index = (a_address-BASE_ADDR) >> log2(MASK_WIDTH).
- Error conditions; any one sets d_error=1, suppresses the memory write and returns d_data=0:
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH*MASK_WIDTH);
  - a_size > log2(MASK_WIDTH);
  - unsupported opcode.
- Error response opcode: AccessAckData for Get; AccessAck otherwise.
- PutFullData writes all bytes; a_mask is ignored.
- Get returns the full word, captured at acceptance, so later writes cannot alter it.
- Low address bits inside a word are ignored. Sub-word sizes are allowed; the master supplies the mask.

Optional Feature:
- Macro: TLUL_MEM_SLAVE_PARTIAL_EN.
- Defined: opcode 3'h2 PutPartialData writes only the bytes where a_mask=1. Response is AccessAck, d_error=0.
- Undefined: 3'h2 is unsupported; it returns AccessAck with d_error=1 and leaves memory unchanged.

Decomposition:
- Package tlul_pkg holds:
  - opcode constants: TL_GET=3'h0, TL_PUT_FULL=3'h1, TL_PUT_PARTIAL=3'h2, TL_ACK=3'h3, TL_ACK_DATA=3'h4;
  - FSM state encoding (IDLE, WAIT, RESP);
  - shared width defaults.
- One sub-module, tlul_mem_array: DEPTH x DATA_WIDTH synchronous byte-enabled RAM, with one write port and one read port.

Test Plan:
- PutFullData 0xA5A5_1234 @0x0, then Get @0x0, LATENCY=1 -> AccessAck d_error=0, then AccessAckData d_data=0xA5A5_1234; d_valid rises 1 cycle after the A handshake.
- LATENCY=5, Get @0x4 -> a_ready low and d_valid high exactly 5 cycles after acceptance.
- Hold d_ready=0 for 7 cycles during RESP -> d_valid, d_opcode and d_data stable, a_ready stays 0; one response only.
- Get @DEPTH*4 (0x40 for defaults) and Put with a_size=3 -> d_error=1, d_data=0, memory unchanged (confirmed by readback).
- With macro defined: Put 0xFFFF_FFFF @0x8, then PutPartial 0x1122_3344 mask 4'b0101 -> readback 0xFF22_FF44. Without the macro -> d_error=1, readback 0xFFFF_FFFF.
- Assert rst_n=0 during WAIT after a Put of 0xDEAD_BEEF @0xC -> d_valid=0 after reset; readback of 0xC returns 0xDEAD_BEEF, since the handshake had completed.
